// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and derivation helpers
package vga_timing_pkg;

    localparam int COORD_W = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int TICK_DIV_DEF  = 4;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int axis_total(int display, int front, int sync, int back);
        return display + front + sync + back;
    endfunction

    function automatic int sync_start(int display, int front);
        return display + front;
    endfunction

    function automatic int sync_end(int display, int front, int sync);
        return display + front + sync;
    endfunction

    // Half-open window test; int compare keeps an end bound of 1024 representable.
    function automatic logic in_window(coord_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// rtl/pixel_tick_div.sv - free-running divider producing a one-clk pixel enable every TICK_DIV cycles
module pixel_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    if ((TICK_DIV < 2) || (TICK_DIV > 16)) begin : g_div_range_err
        $error("pixel_tick_div: TICK_DIV must be in 2..16");
    end

    logic [CW-1:0] tick_cnt_q;
    logic [CW-1:0] tick_cnt_d;

    assign tick_cnt_d = (tick_cnt_q == LAST) ? '0 : tick_cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign p_tick = (tick_cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator; optional frame counter enabled by VGA_FRAME_CNT_EN
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL  = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = sync_start(H_DISPLAY, H_FRONT);
    localparam int HS_END   = sync_end(H_DISPLAY, H_FRONT, H_SYNC);
    localparam int VS_START = sync_start(V_DISPLAY, V_FRONT);
    localparam int VS_END   = sync_end(V_DISPLAY, V_FRONT, V_SYNC);
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if ((H_TOTAL > COORD_LIMIT) || (V_TOTAL > COORD_LIMIT)) begin : g_total_range_err
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic   tick;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   video_on_q, video_on_d;
    logic   frame_start_q, frame_start_d;

    pixel_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .p_tick(tick)
    );

    // Sync and blanking decode from the next coordinates so they land on the same edge as x/y.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + coord_t'(1);
                end
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
        hsync_d    = !in_window(x_d, HS_START, HS_END);
        vsync_d    = !in_window(y_d, VS_START, VS_END);
        video_on_d = (int'(x_d) < H_DISPLAY) && (int'(y_d) < V_DISPLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign p_tick      = tick;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench: default-timing line checks plus a shrunken-timing frame model
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       p;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       fs;
    } exp_t;

    typedef struct {
        int   k;
        exp_t e;
    } vec_t;

    // Shrunken timing: 12 pixels x 8 lines, 2 clk per pixel -> 192 clk per frame.
    localparam int S_TD = 2;
    localparam int S_HT = 12;
    localparam int S_VT = 8;
    localparam int S_FRAME = S_TD * S_HT * S_VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_s_n = 1'b0;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_p, d_hs, d_vs, d_vid, d_fs;
    logic s_p, s_hs, s_vs, s_vid, s_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] d_fc, s_fc;
`endif

    int total = 0;
    int bad = 0;
    int k_d = 0;
    int k_s = 0;
    int hs_low = 0;
    int hs_first = -1;
    exp_t sb[$];
    vec_t tbl[14];

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_tick     (d_p),
        .x          (d_x),
        .y          (d_y),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .video_on   (d_vid),
        .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (d_fc)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV (S_TD)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_s_n),
        .p_tick     (s_p),
        .x          (s_x),
        .y          (s_y),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .video_on   (s_vid),
        .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (s_fc)
`endif
    );

    function automatic vec_t mk(int k, int xx, int yy, logic p, logic hs, logic vs, logic vid, logic fs);
        vec_t v;
        v.k = k;
        v.e = {10'(xx), 10'(yy), p, hs, vs, vid, fs};
        return v;
    endfunction

    // Independent reference for the shrunken instance, derived from edges since reset release.
    function automatic exp_t model_s(int k);
        int pix, xx, yy;
        exp_t e;
        pix   = k / S_TD;
        xx    = pix % S_HT;
        yy    = (pix / S_HT) % S_VT;
        e.x   = 10'(xx);
        e.y   = 10'(yy);
        e.p   = ((k % S_TD) == S_TD - 1);
        e.hs  = !((xx >= 8) && (xx < 11));
        e.vs  = !((yy >= 5) && (yy < 7));
        e.vid = (xx < 6) && (yy < 4);
        e.fs  = (k > 0) && ((k % S_FRAME) == 0);
        return e;
    endfunction

    function automatic exp_t sample_d();
        return {d_x, d_y, d_p, d_hs, d_vs, d_vid, d_fs};
    endfunction

    function automatic exp_t sample_s();
        return {s_x, s_y, s_p, s_hs, s_vs, s_vid, s_fs};
    endfunction

    task automatic chk(string name, exp_t got, exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got x=%0d y=%0d p=%b hs=%b vs=%b vid=%b fs=%b want x=%0d y=%0d p=%b hs=%b vs=%b vid=%b fs=%b",
                     name, got.x, got.y, got.p, got.hs, got.vs, got.vid, got.fs,
                     want.x, want.y, want.p, want.hs, want.vs, want.vid, want.fs);
        end
    endtask

    task automatic chk_int(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic adv_d(int target);
        while (k_d < target) begin
            @(posedge clk);
            @(negedge clk);
            k_d++;
            if (k_d <= 3200 && d_hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = k_d;
            end
        end
    endtask

    task automatic adv_s(int target);
        while (k_s < target) begin
            @(posedge clk);
            @(negedge clk);
            k_s++;
        end
    endtask

    // Scoreboarded per-cycle run of the shrunken instance against model_s.
    task automatic run_s(string name, int n, output int fs_cnt, output int fs_first);
        exp_t want;
        fs_cnt = 0;
        fs_first = -1;
        for (int i = 0; i < n; i++) begin
            sb.push_back(model_s(k_s));
            want = sb.pop_front();
            chk($sformatf("%s_k%0d", name, k_s), sample_s(), want);
            if (s_fs === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k_s;
            end
            adv_s(k_s + 1);
        end
    endtask

    initial begin
        int fs_cnt, fs_first;
        exp_t want, rst_val;

        rst_val = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        tbl[0]  = mk(0,    0,   0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[1]  = mk(3,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(4,    1,   0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[3]  = mk(7,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(2559, 639, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[5]  = mk(2560, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(2623, 655, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mk(2624, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(3007, 751, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(3008, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(3199, 799, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(3200, 0,   1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[12] = mk(3203, 0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[13] = mk(4800, 400, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("reset_hold_default", sample_d(), rst_val);
        chk("reset_hold_small", sample_s(), rst_val);

        rst_n = 1'b1;
        k_d = 0;
        for (int i = 0; i < 14; i++) begin
            sb.push_back(tbl[i].e);
            adv_d(tbl[i].k);
            want = sb.pop_front();
            chk($sformatf("line_k%0d", tbl[i].k), sample_d(), want);
        end
        chk_int("hsync_low_clk", hs_low, 384);
        chk_int("hsync_first_low_k", hs_first, 2624);

        // Asynchronous reset mid-line: outputs must clear before the next clock edge.
        #2 rst_n = 1'b0;
        #1 chk("async_reset_default", sample_d(), rst_val);

        @(negedge clk);
        rst_s_n = 1'b1;
        k_s = 0;
        run_s("frame", 2 * S_FRAME + 16, fs_cnt, fs_first);
        chk_int("frame_start_count", fs_cnt, 2);
        chk_int("frame_start_first_k", fs_first, S_FRAME);

        adv_s(2 * S_FRAME + 100);
        chk("small_mid_frame", sample_s(), model_s(2 * S_FRAME + 100));
        #2 rst_s_n = 1'b0;
        #1 chk("async_reset_small", sample_s(), rst_val);
        repeat (2) @(negedge clk);
        chk("reset_held_small", sample_s(), rst_val);

        rst_s_n = 1'b1;
        k_s = 0;
        run_s("resume", S_FRAME + 4, fs_cnt, fs_first);
        chk_int("resume_first_frame_start_k", fs_first, S_FRAME);

`ifdef VGA_FRAME_CNT_EN
        rst_s_n = 1'b0;
        @(negedge clk);
        chk_int("frame_cnt_reset", int'(s_fc), 0);
        rst_s_n = 1'b1;
        k_s = 0;
        for (int f = 1; f <= 257; f++) begin
            adv_s(f * S_FRAME - 1);
            chk_int($sformatf("frame_cnt_pre_%0d", f), int'(s_fc), (f - 1) % 256);
            adv_s(f * S_FRAME);
            chk_int($sformatf("frame_cnt_post_%0d", f), int'(s_fc), f % 256);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
